// File: rtl/phy_mdio_master_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : phy_mdio_master_if
// Description : Command / response handshake bundle for phy_mdio_master.
// Revision    : 1.0 - initial release
// ============================================================================
interface phy_mdio_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [4:0]  cmd_phy_addr;
    logic [4:0]  cmd_reg_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_err;

    // master issues commands and accepts responses; slave is the MDIO engine
    modport master (
        output cmd_valid, cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  cmd_valid, cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/phy_mdio_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : phy_mdio_master
// Description : PHY hardware-reset sequencer plus Clause 22 MDIO master.
//               Optional macro MDIO_PREAMBLE_SUPPRESS_EN: preamble only on
//               the first frame after reset.
// Revision    : 1.0 - initial release
// ============================================================================
module phy_mdio_master #(
    parameter int MDC_DIV         = 50,
    parameter int RST_HOLD_CYCLES = 1250000,
    parameter int RST_WAIT_CYCLES = 6250
) (
    input  wire logic            sys_clk,
    input  wire logic            sys_rst,
    output logic                 mdio_rstn_out,
    output logic                 mdio_clk_out,
    output logic                 mdio_o,
    output logic                 mdio_t,
    input  wire logic            mdio_i,
    output logic                 phy_ready_out,
    phy_mdio_master_if.slave     bus
);
    typedef enum logic [2:0] {
        ST_RST_HOLD = 3'd0,
        ST_RST_WAIT = 3'd1,
        ST_IDLE     = 3'd2,
        ST_FRAME    = 3'd3,
        ST_GAP      = 3'd4,
        ST_RESP     = 3'd5
    } state_t;

    localparam int c_CNT_MAX = (RST_HOLD_CYCLES > RST_WAIT_CYCLES) ? RST_HOLD_CYCLES : RST_WAIT_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_PH_W    = $clog2(MDC_DIV);
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_WAIT_LAST = c_CNT_W'(RST_WAIT_CYCLES - 1);
    localparam logic [c_PH_W-1:0]  c_PH_LAST   = c_PH_W'(MDC_DIV - 1);
    localparam logic [c_PH_W-1:0]  c_PH_HALF   = c_PH_W'(MDC_DIV / 2);
    localparam logic [5:0] c_BIT_TA1  = 6'd46;
    localparam logic [5:0] c_BIT_TA2  = 6'd47;
    localparam logic [5:0] c_BIT_DATA = 6'd48;
    localparam logic [5:0] c_BIT_LAST = 6'd63;

    state_t               r_state,     w_state;
    logic [c_CNT_W-1:0]   r_cnt,       w_cnt;
    logic [c_PH_W-1:0]    r_phase,     w_phase;
    logic [5:0]           r_bit,       w_bit;
    logic [63:0]          r_frame,     w_frame;
    logic                 r_is_read,   w_is_read;
    logic                 r_rstn,      w_rstn;
    logic                 r_mdc,       w_mdc;
    logic                 r_mdio_o,    w_mdio_o;
    logic                 r_mdio_t,    w_mdio_t;
    logic                 r_phy_ready, w_phy_ready;
    logic                 r_cmd_ready, w_cmd_ready;
    logic                 r_rsp_valid, w_rsp_valid;
    logic [15:0]          r_rdata,     w_rdata;
    logic                 r_err,       w_err;
    logic [63:0]          w_new_frame;
    logic [5:0]           w_start;

    // Frame image, MSB = first bit on the wire; read TA/DATA slots are released
    assign w_new_frame = {32'hFFFF_FFFF, 2'b01,
                          bus.cmd_write ? 2'b01 : 2'b10,
                          bus.cmd_phy_addr, bus.cmd_reg_addr,
                          bus.cmd_write ? 2'b10 : 2'b11,
                          bus.cmd_write ? bus.cmd_wdata : 16'hFFFF};

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    logic r_pre_sent;
    assign w_start = r_pre_sent ? 6'd32 : 6'd0;
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            r_pre_sent <= 1'b0;
        else if (r_state == ST_IDLE && bus.cmd_valid && r_cmd_ready)
            r_pre_sent <= 1'b1;
    end
`else
    assign w_start = 6'd0;
`endif

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_phase     = r_phase;
        w_bit       = r_bit;
        w_frame     = r_frame;
        w_is_read   = r_is_read;
        w_rstn      = r_rstn;
        w_mdc       = 1'b0;
        w_mdio_o    = 1'b1;
        w_mdio_t    = 1'b1;
        w_phy_ready = r_phy_ready;
        w_cmd_ready = 1'b0;
        w_rsp_valid = 1'b0;
        w_rdata     = r_rdata;
        w_err       = r_err;
        case (r_state)
            ST_RST_HOLD: begin
                if (r_cnt == c_HOLD_LAST) begin
                    w_cnt   = '0;
                    w_rstn  = 1'b1;
                    w_state = ST_RST_WAIT;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            ST_RST_WAIT: begin
                if (r_cnt == c_WAIT_LAST) begin
                    w_cnt       = '0;
                    w_phy_ready = 1'b1;
                    w_cmd_ready = 1'b1;
                    w_state     = ST_IDLE;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            ST_IDLE: begin
                w_cmd_ready = 1'b1;
                if (bus.cmd_valid && r_cmd_ready) begin
                    w_cmd_ready = 1'b0;
                    w_frame     = w_new_frame;
                    w_is_read   = ~bus.cmd_write;
                    w_bit       = w_start;
                    w_phase     = '0;
                    w_mdio_o    = w_new_frame[~w_start];
                    w_mdio_t    = 1'b0;
                    w_rdata     = '0;
                    w_err       = 1'b0;
                    w_state     = ST_FRAME;
                end
            end
            ST_FRAME: begin
                w_mdio_o = r_mdio_o;
                w_mdio_t = r_mdio_t;
                w_phase  = (r_phase == c_PH_LAST) ? '0 : r_phase + 1'b1;
                w_mdc    = (w_phase >= c_PH_HALF);
                // Sample on the first MDC-high cycle of each bit
                if (r_is_read && r_phase == c_PH_HALF) begin
                    if (r_bit == c_BIT_TA2)
                        w_err = mdio_i;
                    if (r_bit >= c_BIT_DATA)
                        w_rdata = {r_rdata[14:0], mdio_i};
                end
                if (r_phase == c_PH_LAST) begin
                    if (r_bit == c_BIT_LAST) begin
                        w_mdio_o = 1'b1;
                        w_mdio_t = 1'b1;
                        w_state  = ST_GAP;
                    end else begin
                        w_bit    = r_bit + 6'd1;
                        w_mdio_o = r_frame[~w_bit];
                        w_mdio_t = r_is_read && (w_bit >= c_BIT_TA1);
                    end
                end
            end
            ST_GAP: begin
                w_phase = (r_phase == c_PH_LAST) ? '0 : r_phase + 1'b1;
                w_mdc   = (w_phase >= c_PH_HALF);
                if (r_phase == c_PH_LAST) begin
                    w_rsp_valid = 1'b1;
                    w_state     = ST_RESP;
                end
            end
            ST_RESP: begin
                w_rsp_valid = ~bus.rsp_ready;
                if (bus.rsp_ready) begin
                    w_cmd_ready = 1'b1;
                    w_state     = ST_IDLE;
                end
            end
            default: w_state = ST_RST_HOLD;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state     <= ST_RST_HOLD;
            r_cnt       <= '0;
            r_phase     <= '0;
            r_bit       <= '0;
            r_frame     <= '0;
            r_is_read   <= 1'b0;
            r_rstn      <= 1'b0;
            r_mdc       <= 1'b0;
            r_mdio_o    <= 1'b1;
            r_mdio_t    <= 1'b1;
            r_phy_ready <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_phase     <= w_phase;
            r_bit       <= w_bit;
            r_frame     <= w_frame;
            r_is_read   <= w_is_read;
            r_rstn      <= w_rstn;
            r_mdc       <= w_mdc;
            r_mdio_o    <= w_mdio_o;
            r_mdio_t    <= w_mdio_t;
            r_phy_ready <= w_phy_ready;
            r_cmd_ready <= w_cmd_ready;
            r_rsp_valid <= w_rsp_valid;
            r_rdata     <= w_rdata;
            r_err       <= w_err;
        end
    end

    assign mdio_rstn_out = r_rstn;
    assign mdio_clk_out  = r_mdc;
    assign mdio_o        = r_mdio_o;
    assign mdio_t        = r_mdio_t;
    assign phy_ready_out = r_phy_ready;
    assign bus.cmd_ready = r_cmd_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;
endmodule
`default_nettype wire

// File: tb/tb_phy_mdio_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_phy_mdio_master
// Description : Directed self-checking bench for phy_mdio_master.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_phy_mdio_master;
    localparam int D    = 4;
    localparam int HOLD = 100;
    localparam int WAIT = 20;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b0;
    logic mdio_i  = 1'b1;
    logic mdio_rstn_out, mdio_clk_out, mdio_o, mdio_t, phy_ready_out;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic pre_sent = 1'b0;

    phy_mdio_master_if bus();

    phy_mdio_master #(
        .MDC_DIV(D), .RST_HOLD_CYCLES(HOLD), .RST_WAIT_CYCLES(WAIT)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .mdio_rstn_out(mdio_rstn_out), .mdio_clk_out(mdio_clk_out),
        .mdio_o(mdio_o), .mdio_t(mdio_t), .mdio_i(mdio_i),
        .phy_ready_out(phy_ready_out), .bus(bus)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic int frame_start();
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        return pre_sent ? 32 : 0;
`else
        return 0;
`endif
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!phy_ready_out && n < HOLD + WAIT + 10) begin
            @(negedge sys_clk);
            n++;
        end
        n_cmp++;
        if (phy_ready_out !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_timeout actual=%b required=1", phy_ready_out);
        end
        @(negedge sys_clk);
    endtask

    // Returns at the negedge of the handshake cycle (cycle 0)
    task automatic issue(input logic wr, input logic [4:0] pa, input logic [4:0] ra, input logic [15:0] wd);
        int n = 0;
        bus.cmd_write    = wr;
        bus.cmd_phy_addr = pa;
        bus.cmd_reg_addr = ra;
        bus.cmd_wdata    = wd;
        bus.cmd_valid    = 1'b1;
        while (bus.cmd_ready !== 1'b1 && n < 500) begin
            @(negedge sys_clk);
            n++;
        end
        if (bus.cmd_ready !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL cmd_accept_timeout actual=%b required=1", bus.cmd_ready);
        end
        pre_sent = 1'b1;
    endtask

    // Walks one frame plus gap; phy_in[63-k] is what the PHY puts on bit k
    task automatic run_frame(input int start, input logic [63:0] phy_in,
                             output logic [63:0] o_bits, output logic [63:0] t_bits,
                             output int mdc_bad, output int glitch,
                             output logic rv_before, output logic rv_at);
        int nb = 64 - start;
        o_bits = '1; t_bits = '0; mdc_bad = 0; glitch = 0; rv_before = 1'bx;
        for (int c = 1; c <= (nb + 1) * D; c++) begin
            int k, p;
            @(negedge sys_clk);
            if (c == 1) bus.cmd_valid = 1'b0;
            k = start + (c - 1) / D;
            p = (c - 1) % D;
            if (mdio_clk_out !== (p >= D / 2)) mdc_bad++;
            if (k < 64) begin
                if (p == 0) begin
                    o_bits[63-k] = mdio_o;
                    t_bits[63-k] = mdio_t;
                    mdio_i = phy_in[63-k];
                end else if (mdio_o !== o_bits[63-k] || mdio_t !== t_bits[63-k]) begin
                    glitch++;
                end
            end else if (mdio_o !== 1'b1 || mdio_t !== 1'b1) begin
                glitch++;
            end
            if (c == (nb + 1) * D) rv_before = bus.rsp_valid;
        end
        mdio_i = 1'b1;
        @(negedge sys_clk);
        rv_at = bus.rsp_valid;
    endtask

    task automatic consume_rsp();
        bus.rsp_ready = 1'b1;
        @(negedge sys_clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [22:0] snap;
        logic rstn_a, rstn_b, rdy_a, rdy_b, crdy_b;
        #2 sys_rst = 1'b1;
        @(negedge sys_clk);
        snap = {mdio_rstn_out, mdio_clk_out, mdio_o, mdio_t, phy_ready_out,
                bus.cmd_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err};
        n_cmp++;
        if (snap !== {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_values actual=%h required=%h", snap, 23'h180000);
        end
        sys_rst = 1'b0;
        for (int n = 1; n <= HOLD + WAIT; n++) begin
            @(negedge sys_clk);
            if (n == HOLD - 1) rstn_a = mdio_rstn_out;
            if (n == HOLD) rstn_b = mdio_rstn_out;
            if (n == HOLD + WAIT - 1) rdy_a = phy_ready_out;
            if (n == HOLD + WAIT) begin
                rdy_b  = phy_ready_out;
                crdy_b = bus.cmd_ready;
            end
        end
        n_cmp++;
        if (rstn_a !== 1'b0) begin n_bad++; $display("FAIL rstn_hold_end actual=%b required=0", rstn_a); end
        n_cmp++;
        if (rstn_b !== 1'b1) begin n_bad++; $display("FAIL rstn_release actual=%b required=1", rstn_b); end
        n_cmp++;
        if (rdy_a !== 1'b0) begin n_bad++; $display("FAIL ready_early actual=%b required=0", rdy_a); end
        n_cmp++;
        if (rdy_b !== 1'b1) begin n_bad++; $display("FAIL ready_at_120 actual=%b required=1", rdy_b); end
        n_cmp++;
        if (crdy_b !== 1'b1) begin n_bad++; $display("FAIL cmd_ready_at_120 actual=%b required=1", crdy_b); end
        pre_sent = 1'b0;
    endtask

    task automatic test_write();
        logic [63:0] o, t;
        int mb, gl, st;
        logic rb, ra;
        st = frame_start();
        issue(1'b1, 5'h01, 5'h00, 16'h1140);
        run_frame(st, '1, o, t, mb, gl, rb, ra);
        n_cmp++;
        if (o !== 64'hFFFF_FFFF_5082_1140) begin n_bad++; $display("FAIL wr_bits actual=%h required=%h", o, 64'hFFFF_FFFF_5082_1140); end
        n_cmp++;
        if (t !== 64'h0) begin n_bad++; $display("FAIL wr_tristate actual=%h required=0", t); end
        n_cmp++;
        if (mb != 0 || gl != 0) begin n_bad++; $display("FAIL wr_timing actual=mdc_bad:%0d glitch:%0d required=0/0", mb, gl); end
        n_cmp++;
        if ({rb, ra} !== 2'b01) begin n_bad++; $display("FAIL wr_rsp_valid_edge actual=%b required=01", {rb, ra}); end
        n_cmp++;
        if ({bus.rsp_rdata, bus.rsp_err} !== 17'h0) begin n_bad++; $display("FAIL wr_rsp actual=%h/%b required=0000/0", bus.rsp_rdata, bus.rsp_err); end
        consume_rsp();
    endtask

    task automatic test_read();
        logic [63:0] o, t;
        int mb, gl, st;
        logic rb, ra;
        st = frame_start();
        issue(1'b0, 5'h01, 5'h02, 16'h0000);
        run_frame(st, {46'h3FFF_FFFF_FFFF, 2'b10, 16'h2000}, o, t, mb, gl, rb, ra);
        n_cmp++;
        if (o[63:18] !== 46'h3FFF_FFFF_D822) begin n_bad++; $display("FAIL rd_bits actual=%h required=%h", o[63:18], 46'h3FFF_FFFF_D822); end
        n_cmp++;
        if (t !== 64'h3FFFF) begin n_bad++; $display("FAIL rd_tristate actual=%h required=%h", t, 64'h3FFFF); end
        n_cmp++;
        if (mb != 0 || gl != 0 || {rb, ra} !== 2'b01) begin n_bad++; $display("FAIL rd_timing actual=%0d/%0d/%b required=0/0/01", mb, gl, {rb, ra}); end
        n_cmp++;
        if ({bus.rsp_rdata, bus.rsp_err} !== {16'h2000, 1'b0}) begin n_bad++; $display("FAIL rd_rsp actual=%h/%b required=2000/0", bus.rsp_rdata, bus.rsp_err); end
        consume_rsp();
    endtask

    task automatic test_ta_error();
        logic [63:0] o, t;
        int mb, gl, st;
        logic rb, ra;
        st = frame_start();
        issue(1'b0, 5'h03, 5'h01, 16'h0000);
        run_frame(st, '1, o, t, mb, gl, rb, ra);
        n_cmp++;
        if ({bus.rsp_rdata, bus.rsp_err} !== {16'hFFFF, 1'b1}) begin n_bad++; $display("FAIL ta_err_rsp actual=%h/%b required=ffff/1", bus.rsp_rdata, bus.rsp_err); end
        consume_rsp();
    endtask

    task automatic test_backpressure();
        logic [63:0] o, t;
        int mb, gl, st, bad;
        logic rb, ra;
        logic [22:0] snap;
        st = frame_start();
        issue(1'b0, 5'h01, 5'h03, 16'h0000);
        run_frame(st, {46'h3FFF_FFFF_FFFF, 2'b10, 16'hBEEF}, o, t, mb, gl, rb, ra);
        bad = 0;
        for (int n = 0; n < 50; n++) begin
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 16'hBEEF || bus.rsp_err !== 1'b0 || bus.cmd_ready !== 1'b0) bad++;
            @(negedge sys_clk);
        end
        n_cmp++;
        if (bad != 0) begin n_bad++; $display("FAIL bp_hold actual=%0d_bad_cycles required=0", bad); end
        sys_rst = 1'b1;
        #1;
        snap = {mdio_rstn_out, mdio_clk_out, mdio_o, mdio_t, phy_ready_out,
                bus.cmd_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err};
        n_cmp++;
        if (snap !== {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0}) begin
            n_bad++;
            $display("FAIL resp_reset actual=%h required=%h", snap, 23'h180000);
        end
        @(negedge sys_clk);
        sys_rst = 1'b0;
        pre_sent = 1'b0;
        wait_ready();
    endtask

    task automatic test_midframe_reset();
        logic [22:0] snap;
        logic [1:0] pre;
        int bad;
        issue(1'b1, 5'h05, 5'h04, 16'hA5A5);
        for (int c = 1; c <= 20 * D + 2; c++) begin
            @(negedge sys_clk);
            if (c == 1) bus.cmd_valid = 1'b0;
        end
        pre = {mdio_t, mdio_clk_out};
        n_cmp++;
        if (pre !== 2'b00) begin n_bad++; $display("FAIL mid_pre_state actual=%b required=00", pre); end
        sys_rst = 1'b1;
        #1;
        snap = {mdio_rstn_out, mdio_clk_out, mdio_o, mdio_t, phy_ready_out,
                bus.cmd_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err};
        n_cmp++;
        if (snap !== {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0}) begin
            n_bad++;
            $display("FAIL mid_reset actual=%h required=%h", snap, 23'h180000);
        end
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        pre_sent = 1'b0;
        bad = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge sys_clk);
            if (mdio_clk_out !== 1'b0 || mdio_t !== 1'b1 || mdio_rstn_out !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin n_bad++; $display("FAIL mid_abort actual=%0d_bad_cycles required=0", bad); end
        wait_ready();
    endtask

    task automatic test_back_to_back();
        int hs[3];
        int rises[3];
        int nhs = 0, r = 0, cyc = 0;
        logic prev = 1'b0;
        int exp_gap2, exp_rise2;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        exp_gap2  = 33 * D + 2;
        exp_rise2 = 33;
`else
        exp_gap2  = 65 * D + 2;
        exp_rise2 = 65;
`endif
        bus.rsp_ready    = 1'b1;
        bus.cmd_write    = 1'b1;
        bus.cmd_phy_addr = 5'h01;
        bus.cmd_reg_addr = 5'h00;
        bus.cmd_wdata    = 16'h1140;
        bus.cmd_valid    = 1'b1;
        while (nhs < 3 && cyc < 1000) begin
            if (mdio_clk_out && !prev) r++;
            prev = mdio_clk_out;
            if (bus.cmd_valid && bus.cmd_ready) begin
                hs[nhs]    = cyc;
                rises[nhs] = r;
                nhs++;
            end
            @(negedge sys_clk);
            cyc++;
        end
        bus.cmd_valid = 1'b0;
        n_cmp++;
        if (nhs != 3) begin
            n_bad++;
            $display("FAIL b2b_handshakes actual=%0d required=3", nhs);
        end else begin
            n_cmp++;
            if (hs[1] - hs[0] != 65 * D + 2) begin n_bad++; $display("FAIL b2b_period1 actual=%0d required=%0d", hs[1] - hs[0], 65 * D + 2); end
            n_cmp++;
            if (hs[2] - hs[1] != exp_gap2) begin n_bad++; $display("FAIL b2b_period2 actual=%0d required=%0d", hs[2] - hs[1], exp_gap2); end
            n_cmp++;
            if (rises[1] - rises[0] != 65) begin n_bad++; $display("FAIL b2b_bits1 actual=%0d required=65", rises[1] - rises[0]); end
            n_cmp++;
            if (rises[2] - rises[1] != exp_rise2) begin n_bad++; $display("FAIL b2b_bits2 actual=%0d required=%0d", rises[2] - rises[1], exp_rise2); end
        end
        repeat (300) @(negedge sys_clk);
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        bus.cmd_valid    = 1'b0;
        bus.cmd_write    = 1'b0;
        bus.cmd_phy_addr = 5'h00;
        bus.cmd_reg_addr = 5'h00;
        bus.cmd_wdata    = 16'h0000;
        bus.rsp_ready    = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_ta_error();
        test_backpressure();
        test_midframe_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
